// File: rtl/mux_arb_n_if.sv
// Streaming bus for mux_arb_n: N input channels, force-select control and one output channel.
// The master modport is the producer/consumer side; the slave modport is the multiplexer.
interface mux_arb_n_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               force_en;
  logic [SELW-1:0]    force_sel;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;

  modport master (
    output in_valid, in_data, force_en, force_sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, force_en, force_sel, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_arb_n.sv
// N-channel valid/ready multiplexer with one output register stage and forced-select override.
// Arbitration is fixed priority (lowest index) by default; define MUX_ARB_RR_EN for round-robin.
module mux_arb_n #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic         clk,
  input  logic         reset,
  mux_arb_n_if.slave   bus
);
  localparam int SELW = $clog2(N);

  logic              load;
  logic              xfer;
  logic [N-1:0]      fgrant;
  logic [N-1:0]      agrant;
  logic [N-1:0]      grant;
  logic [N-1:0]      rdy;
  logic [SELW-1:0]   aidx;
  logic [SELW-1:0]   gidx;

  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [SELW-1:0]   out_sel_q;

  assign load = ~out_valid_q | bus.out_ready;

  // Forced grant: out-of-range indices grant nothing.
  always_comb begin
    fgrant = '0;
    if (32'(bus.force_sel) < N) begin
      fgrant[bus.force_sel] = bus.in_valid[bus.force_sel];
    end
  end

`ifdef MUX_ARB_RR_EN
  logic [SELW-1:0] rr_ptr;

  // Search begins at rr_ptr and wraps from N-1 back to 0.
  always_comb begin
    logic            found;
    logic [SELW-1:0] idx;
    int unsigned     c;
    agrant = '0;
    aidx   = '0;
    found  = 1'b0;
    idx    = '0;
    c      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      c = 32'(rr_ptr) + k;
      if (c >= N) begin
        c = c - N;
      end
      idx = c[SELW-1:0];
      if (!found && bus.in_valid[idx]) begin
        found       = 1'b1;
        aidx        = idx;
        agrant[idx] = 1'b1;
      end
    end
  end
`else
  always_comb begin
    logic            found;
    logic [SELW-1:0] idx;
    agrant = '0;
    aidx   = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = SELW'(k);
      if (!found && bus.in_valid[idx]) begin
        found       = 1'b1;
        aidx        = idx;
        agrant[idx] = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    grant = bus.force_en ? fgrant : agrant;
    gidx  = bus.force_en ? bus.force_sel : aidx;
  end

  // Reset blocks acceptance so no word is consumed while the register is being cleared.
  assign rdy  = grant & {N{load & ~reset}};
  assign xfer = |rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data[int'(gidx)*WIDTH +: WIDTH];
      out_sel_q   <= gidx;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef MUX_ARB_RR_EN
  // Only arbitrated transfers advance the pointer; forced ones leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (xfer && !bus.force_en) begin
      rr_ptr <= (gidx == SELW'(N - 1)) ? '0 : gidx + SELW'(1);
    end
  end
`endif

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule
